// File: rtl/fp_normalizer_packer.sv
// fp_normalizer_packer: takes a sign, a pre-normalization biased exponent and
// a double-width product mantissa, normalizes the mantissa one shift per
// cycle, rounds half-up, checks the exponent range and packs
// {sign, exponent, fraction} into a single word. Valid/ready handshakes sit on
// both sides and only one operation is in flight at a time.
// Port widths assume NB_TOTAL == 1+NB_EXP+NB_MANT and NB_RAW == 2*NB_MANT+2.
module fp_normalizer_packer #(
    parameter int NB_MANT  = 8,
    parameter int NB_EXP   = 4,
    parameter int NB_TOTAL = 13,
    parameter int NB_RAW   = 18
) (
    input  logic                       CLK,
    input  logic                       RST_N,
    input  logic                       IN_VALID,
    output logic                       IN_READY,
    input  logic                       SIGN_IN,
    input  logic signed [NB_EXP+1:0]   EXP_IN,
    input  logic        [NB_RAW-1:0]   MANT_IN,
    output logic                       OUT_VALID,
    input  logic                       OUT_READY,
    output logic        [NB_TOTAL-1:0] OUT,
    output logic                       OVF,
    output logic                       UNF
);

    // Internal exponent carries enough headroom for all left shifts and the
    // right-shift/rounding increments without wrapping.
    localparam int NB_E = NB_EXP + 3;

    localparam logic signed [NB_E-1:0] EXP_MAX = NB_E'((2 ** NB_EXP) - 1);
    localparam logic [NB_EXP-1:0]      EXP_SAT = NB_EXP'((2 ** NB_EXP) - 2);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        NORM  = 2'd1,
        ROUND = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t                  state;
    logic                    sign_r;
    logic                    zero_r;
    logic signed [NB_E-1:0]  exp_r;
    logic [NB_RAW-1:0]       mant_r;

    logic [NB_MANT-1:0]      frac_raw;
    logic                    round_bit;
    logic [NB_MANT:0]        frac_sum;
    logic [NB_MANT-1:0]      frac_rnd;
    logic signed [NB_E-1:0]  exp_rnd;
    logic                    exp_under;
    logic                    exp_over;

    // Half-up rounding of the normalized mantissa and range classification of
    // the post-rounding exponent; a fraction carry-out wraps frac to zero.
    always_comb begin
        frac_raw  = mant_r[NB_RAW-3 -: NB_MANT];
        round_bit = mant_r[NB_RAW-3-NB_MANT];
        frac_sum  = {1'b0, frac_raw} + {{NB_MANT{1'b0}}, round_bit};
        frac_rnd  = frac_sum[NB_MANT-1:0];
        exp_rnd   = exp_r + {{(NB_E-1){1'b0}}, frac_sum[NB_MANT]};
        exp_under = exp_rnd[NB_E-1] || (exp_rnd == '0);
        exp_over  = !exp_rnd[NB_E-1] && (exp_rnd >= EXP_MAX);
    end

    // Control FSM with registered handshake outputs and packed result.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state     <= IDLE;
            sign_r    <= 1'b0;
            zero_r    <= 1'b0;
            exp_r     <= '0;
            mant_r    <= '0;
            IN_READY  <= 1'b1;
            OUT_VALID <= 1'b0;
            OUT       <= '0;
            OVF       <= 1'b0;
            UNF       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (IN_VALID) begin
                        sign_r   <= SIGN_IN;
                        exp_r    <= {EXP_IN[NB_EXP+1], EXP_IN};
                        mant_r   <= MANT_IN;
                        zero_r   <= 1'b0;
                        IN_READY <= 1'b0;
                        state    <= NORM;
                    end
                end
                NORM: begin
                    if (mant_r == '0) begin
                        zero_r <= 1'b1;
                        state  <= ROUND;
                    end else if (mant_r[NB_RAW-1]) begin
                        mant_r <= {1'b0, mant_r[NB_RAW-1:1]};
                        exp_r  <= exp_r + NB_E'(1);
                        state  <= ROUND;
                    end else if (mant_r[NB_RAW-2]) begin
                        state <= ROUND;
                    end else begin
                        // Nonzero and below the leading position, so this
                        // terminates within NB_RAW-2 shifts.
                        mant_r <= {mant_r[NB_RAW-2:0], 1'b0};
                        exp_r  <= exp_r - NB_E'(1);
                    end
                end
                ROUND: begin
                    OUT_VALID <= 1'b1;
                    state     <= DONE;
                    if (zero_r) begin
                        OUT <= {sign_r, {NB_EXP{1'b0}}, {NB_MANT{1'b0}}};
                        OVF <= 1'b0;
                        UNF <= 1'b0;
                    end else if (exp_under) begin
                        OUT <= {sign_r, {NB_EXP{1'b0}}, {NB_MANT{1'b0}}};
                        OVF <= 1'b0;
                        UNF <= 1'b1;
                    end else if (exp_over) begin
                        OUT <= {sign_r, EXP_SAT, {NB_MANT{1'b1}}};
                        OVF <= 1'b1;
                        UNF <= 1'b0;
                    end else begin
                        OUT <= {sign_r, exp_rnd[NB_EXP-1:0], frac_rnd};
                        OVF <= 1'b0;
                        UNF <= 1'b0;
                    end
                end
                DONE: begin
                    if (OUT_READY) begin
                        OUT_VALID <= 1'b0;
                        IN_READY  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fp_normalizer_packer.sv
// Directed bench for fp_normalizer_packer with hand-computed packed results,
// latencies (edges from the accept edge inclusive to OUT_VALID high) and flags.
module tb_fp_normalizer_packer;

    logic               CLK;
    logic               RST_N;
    logic               IN_VALID;
    logic               IN_READY;
    logic               SIGN_IN;
    logic signed [5:0]  EXP_IN;
    logic [17:0]        MANT_IN;
    logic               OUT_VALID;
    logic               OUT_READY;
    logic [12:0]        out_word;
    logic               OVF;
    logic               UNF;

    int total;
    int bad;

    fp_normalizer_packer #(
        .NB_MANT  (8),
        .NB_EXP   (4),
        .NB_TOTAL (13),
        .NB_RAW   (18)
    ) dut (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .IN_VALID  (IN_VALID),
        .IN_READY  (IN_READY),
        .SIGN_IN   (SIGN_IN),
        .EXP_IN    (EXP_IN),
        .MANT_IN   (MANT_IN),
        .OUT_VALID (OUT_VALID),
        .OUT_READY (OUT_READY),
        .OUT       (out_word),
        .OVF       (OVF),
        .UNF       (UNF)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Presents one operand (waiting for IN_READY), counts edges from the
    // accept edge until OUT_VALID is seen; leaves the result in DONE.
    task automatic start_op(input logic s, input logic signed [5:0] e,
                            input logic [17:0] m, output int lat);
        int w;
        w = 0;
        while (!IN_READY && w < 100) begin
            @(posedge CLK); #1; w++;
        end
        SIGN_IN  = s;
        EXP_IN   = e;
        MANT_IN  = m;
        IN_VALID = 1'b1;
        @(posedge CLK); #1;
        IN_VALID = 1'b0;
        lat = 1;
        while (!OUT_VALID && lat < 100) begin
            @(posedge CLK); #1; lat++;
        end
    endtask

    task automatic release_op();
        OUT_READY = 1'b1;
        @(posedge CLK); #1;
        OUT_READY = 1'b0;
    endtask

    task automatic test_reset();
        RST_N = 1'b0;
        IN_VALID = 1'b0; OUT_READY = 1'b0;
        SIGN_IN = 1'b0; EXP_IN = '0; MANT_IN = '0;
        repeat (2) @(posedge CLK);
        #1;
        total++;
        if ({OUT_VALID, out_word, OVF, UNF} !== 16'h0000) begin
            bad++;
            $display("FAIL reset_outputs: got valid=%b out=%h ovf=%b unf=%b, want 0 0000 0 0",
                     OUT_VALID, out_word, OVF, UNF);
        end
        RST_N = 1'b1;
        @(posedge CLK); #1;
        total++;
        if (IN_READY !== 1'b1) begin
            bad++;
            $display("FAIL reset_in_ready: got %b want 1", IN_READY);
        end
    endtask

    task automatic test_unity();
        int lat;
        start_op(1'b0, 6'sd7, 18'h10000, lat);
        total++;
        if (lat !== 3) begin
            bad++; $display("FAIL unity_latency: got %0d want 3", lat);
        end
        total++;
        if ({out_word, OVF, UNF} !== {13'h0700, 2'b00}) begin
            bad++; $display("FAIL unity_out: got %h ovf=%b unf=%b want 0700 0 0", out_word, OVF, UNF);
        end
        total++;
        if (IN_READY !== 1'b0) begin
            bad++; $display("FAIL unity_in_ready_done: got %b want 0", IN_READY);
        end
        release_op();
        total++;
        if ({OUT_VALID, IN_READY, out_word} !== {2'b01, 13'h0700}) begin
            bad++; $display("FAIL unity_release: got valid=%b ready=%b out=%h want 0 1 0700",
                            OUT_VALID, IN_READY, out_word);
        end
    endtask

    task automatic test_right_shift();
        int lat;
        start_op(1'b0, 6'sd7, 18'h30000, lat);
        total++;
        if (lat !== 3) begin
            bad++; $display("FAIL rshift_latency: got %0d want 3", lat);
        end
        total++;
        if ({out_word, OVF, UNF} !== {13'h0880, 2'b00}) begin
            bad++; $display("FAIL rshift_out: got %h ovf=%b unf=%b want 0880 0 0", out_word, OVF, UNF);
        end
        release_op();
    endtask

    task automatic test_left_shift();
        int lat;
        start_op(1'b0, 6'sd9, 18'h04000, lat);
        total++;
        if (lat !== 5) begin
            bad++; $display("FAIL lshift_latency: got %0d want 5", lat);
        end
        total++;
        if ({out_word, OVF, UNF} !== {13'h0700, 2'b00}) begin
            bad++; $display("FAIL lshift_out: got %h ovf=%b unf=%b want 0700 0 0", out_word, OVF, UNF);
        end
        release_op();
        // Maximum normalization distance: 16 left shifts, exp 20-16=4.
        start_op(1'b0, 6'sd20, 18'h00001, lat);
        total++;
        if (lat !== 19) begin
            bad++; $display("FAIL lshift_max_latency: got %0d want 19", lat);
        end
        total++;
        if ({out_word, OVF, UNF} !== {13'h0400, 2'b00}) begin
            bad++; $display("FAIL lshift_max_out: got %h ovf=%b unf=%b want 0400 0 0", out_word, OVF, UNF);
        end
        release_op();
    endtask

    task automatic test_zero();
        int lat;
        start_op(1'b1, 6'sd7, 18'h00000, lat);
        total++;
        if (lat !== 3) begin
            bad++; $display("FAIL zero_latency: got %0d want 3", lat);
        end
        total++;
        if ({out_word, OVF, UNF} !== {13'h1000, 2'b00}) begin
            bad++; $display("FAIL zero_out: got %h ovf=%b unf=%b want 1000 0 0", out_word, OVF, UNF);
        end
        release_op();
    endtask

    task automatic test_rounding();
        int lat;
        start_op(1'b1, 6'sd7, 18'h1FF80, lat);
        total++;
        if ({out_word, OVF, UNF} !== {13'h1800, 2'b00}) begin
            bad++; $display("FAIL round_carry: got %h ovf=%b unf=%b want 1800 0 0", out_word, OVF, UNF);
        end
        release_op();
        // Exactly half an ulp rounds up.
        start_op(1'b0, 6'sd7, 18'h10080, lat);
        total++;
        if ({out_word, OVF, UNF} !== {13'h0701, 2'b00}) begin
            bad++; $display("FAIL round_half_up: got %h ovf=%b unf=%b want 0701 0 0", out_word, OVF, UNF);
        end
        release_op();
        // Just below half rounds down.
        start_op(1'b0, 6'sd7, 18'h1017F, lat);
        total++;
        if ({out_word, OVF, UNF} !== {13'h0701, 2'b00}) begin
            bad++; $display("FAIL round_below_half: got %h ovf=%b unf=%b want 0701 0 0", out_word, OVF, UNF);
        end
        release_op();
    endtask

    task automatic test_range();
        int lat;
        start_op(1'b0, 6'sd14, 18'h20000, lat);
        total++;
        if ({out_word, OVF, UNF} !== {13'h0EFF, 2'b10}) begin
            bad++; $display("FAIL overflow: got %h ovf=%b unf=%b want 0EFF 1 0", out_word, OVF, UNF);
        end
        release_op();
        // Largest exponent that still fits.
        start_op(1'b0, 6'sd14, 18'h10000, lat);
        total++;
        if ({out_word, OVF, UNF} !== {13'h0E00, 2'b00}) begin
            bad++; $display("FAIL max_normal: got %h ovf=%b unf=%b want 0E00 0 0", out_word, OVF, UNF);
        end
        release_op();
        start_op(1'b0, 6'sd0, 18'h10000, lat);
        total++;
        if ({out_word, OVF, UNF} !== {13'h0000, 2'b01}) begin
            bad++; $display("FAIL underflow_zero_exp: got %h ovf=%b unf=%b want 0000 0 1", out_word, OVF, UNF);
        end
        release_op();
        start_op(1'b1, -6'sd3, 18'h10000, lat);
        total++;
        if ({out_word, OVF, UNF} !== {13'h1000, 2'b01}) begin
            bad++; $display("FAIL underflow_neg_exp: got %h ovf=%b unf=%b want 1000 0 1", out_word, OVF, UNF);
        end
        release_op();
        // Smallest exponent that stays normal.
        start_op(1'b0, 6'sd1, 18'h10000, lat);
        total++;
        if ({out_word, OVF, UNF} !== {13'h0100, 2'b00}) begin
            bad++; $display("FAIL min_normal: got %h ovf=%b unf=%b want 0100 0 0", out_word, OVF, UNF);
        end
        release_op();
    endtask

    task automatic test_back_pressure();
        int lat;
        start_op(1'b0, 6'sd14, 18'h20000, lat);
        // A new operand offered while busy must be ignored.
        SIGN_IN = 1'b1; EXP_IN = 6'sd3; MANT_IN = 18'h12345; IN_VALID = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge CLK); #1;
            total++;
            if ({OUT_VALID, IN_READY, out_word, OVF, UNF} !== {2'b10, 13'h0EFF, 2'b10}) begin
                bad++;
                $display("FAIL hold_cycle%0d: got valid=%b ready=%b out=%h ovf=%b unf=%b want 1 0 0EFF 1 0",
                         i, OUT_VALID, IN_READY, out_word, OVF, UNF);
            end
        end
        IN_VALID = 1'b0;
        release_op();
        total++;
        if ({OUT_VALID, IN_READY, out_word} !== {2'b01, 13'h0EFF}) begin
            bad++; $display("FAIL hold_release: got valid=%b ready=%b out=%h want 0 1 0EFF",
                            OUT_VALID, IN_READY, out_word);
        end
    endtask

    task automatic test_reset_mid_norm();
        int lat;
        int w;
        w = 0;
        while (!IN_READY && w < 100) begin
            @(posedge CLK); #1; w++;
        end
        SIGN_IN = 1'b0; EXP_IN = 6'sd20; MANT_IN = 18'h00001; IN_VALID = 1'b1;
        @(posedge CLK); #1;
        IN_VALID = 1'b0;
        repeat (3) @(posedge CLK);
        #2;
        RST_N = 1'b0;
        #1;
        total++;
        if ({OUT_VALID, out_word, OVF, UNF} !== 16'h0000) begin
            bad++; $display("FAIL midnorm_reset: got valid=%b out=%h ovf=%b unf=%b want 0 0000 0 0",
                            OUT_VALID, out_word, OVF, UNF);
        end
        @(posedge CLK); #1;
        RST_N = 1'b1;
        @(posedge CLK); #1;
        total++;
        if ({IN_READY, OUT_VALID} !== 2'b10) begin
            bad++; $display("FAIL midnorm_release: got ready=%b valid=%b want 1 0", IN_READY, OUT_VALID);
        end
        start_op(1'b0, 6'sd7, 18'h30000, lat);
        total++;
        if (lat !== 3 || {out_word, OVF, UNF} !== {13'h0880, 2'b00}) begin
            bad++; $display("FAIL midnorm_next_op: got lat=%0d out=%h ovf=%b unf=%b want 3 0880 0 0",
                            lat, out_word, OVF, UNF);
        end
        release_op();
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_unity();
        test_right_shift();
        test_left_shift();
        test_zero();
        test_rounding();
        test_range();
        test_back_pressure();
        test_reset_mid_norm();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
